// File: rtl/wb_ext_arbiter.sv
// wb_ext_arbiter
//   Round-robin Wishbone B3 arbiter: NUM_MASTERS tile-side masters share one
//   external slave port. A grant is held for the whole cyc, so bursts are
//   never split. A watchdog ends stalled strobes with an error.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   m_*_i                 flattened master buses (master i at slice i)
//   m_ack_o/err_o/rty_o   per-master terminations; m_dat_o broadcasts read data
//   s_*_o / s_*_i         single slave port
//   grant_o               one-hot current grant (0 when idle)
//   timeout_cnt_o         saturating count of watchdog errors
module wb_ext_arbiter #(
    parameter int NUM_MASTERS = 9,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_cab_i,
    input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic [DW-1:0]             m_dat_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic                      s_cab_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    input  logic [DW-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic [7:0]                timeout_cnt_o
);

    localparam int SW  = DW / 8;
    localparam int IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IW-1:0]          last;      // in BUSY this is the granted index
    logic [WCW-1:0]         wcnt;
    logic [7:0]             timeout_cnt;

    logic                   active;
    logic                   resp;
    logic                   wd_fire;
    logic                   pick_vld;
    logic [IW-1:0]          pick;
    logic [NUM_MASTERS-1:0] pick_oh;
    int                     idx;

    assign active  = (state == BUSY) && m_cyc_i[last];
    assign resp    = s_ack_i | s_err_i | s_rty_i;
    assign grant_o = grant;
    assign timeout_cnt_o = timeout_cnt;
    assign m_dat_o = s_dat_i;

    // A real slave response in the firing cycle takes precedence.
    generate
        if (TIMEOUT > 0) begin : g_wd
            assign wd_fire = active && m_stb_i[last] && !resp && (wcnt == WCW'(TIMEOUT));
        end else begin : g_nowd
            assign wd_fire = 1'b0;
        end
    endgenerate

    // Round-robin scan from last+1. The loop runs backwards so the nearest
    // requester overwrites farther ones. On release (BUSY) the current owner,
    // which is the final candidate (k == NUM_MASTERS), is excluded.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (m_cyc_i[idx] && !(state == BUSY && k == NUM_MASTERS)) begin
                pick_vld = 1'b1;
                pick     = IW'(idx);
            end
        end
        pick_oh = NUM_MASTERS'(1) << pick;
    end

    // Combinational slave path; everything is zero unless the owner holds cyc.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cab_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (active) begin
            s_adr_o       = m_adr_i[last*AW +: AW];
            s_dat_o       = m_dat_i[last*DW +: DW];
            s_sel_o       = m_sel_i[last*SW +: SW];
            s_we_o        = m_we_i[last];
            s_cab_o       = m_cab_i[last];
            s_cti_o       = m_cti_i[last*3 +: 3];
            s_bte_o       = m_bte_i[last*2 +: 2];
            s_cyc_o       = !wd_fire;
            s_stb_o       = m_stb_i[last] && !wd_fire;
            m_ack_o[last] = s_ack_i;
            m_err_o[last] = s_err_i | wd_fire;
            m_rty_o[last] = s_rty_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last        <= IW'(NUM_MASTERS - 1);
            wcnt        <= '0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= BUSY;
                        grant <= pick_oh;
                        last  <= pick;
                        wcnt  <= '0;
                    end
                end
                BUSY: begin
                    if (!m_cyc_i[last]) begin
                        wcnt <= '0;
                        if (pick_vld) begin
                            grant <= pick_oh;
                            last  <= pick;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else begin
                        if (TIMEOUT == 0 || resp || !m_stb_i[last] || wd_fire)
                            wcnt <= '0;
                        else
                            wcnt <= wcnt + 1'b1;
                        if (wd_fire && timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Testbench for wb_ext_arbiter: randomized master/slave traffic compared each
// cycle against a round-robin reference model, plus a directed single read,
// watchdog/race phases and an asynchronous reset mid-transfer.
module tb_wb_ext_arbiter;

    localparam int N  = 9;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_cyc, m_stb, m_we, m_cab;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [N-1:0]    m_ack, m_err, m_rty;
    logic [DW-1:0]   m_rdat;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat;
    logic [SW-1:0]   s_sel;
    logic            s_cyc, s_stb, s_we, s_cab;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic            s_ack, s_err, s_rty;
    logic [DW-1:0]   s_rdat;
    logic [N-1:0]    grant;
    logic [7:0]      tcnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: owner (-1 idle), last owner, wait count, error count
    int mg, mlast, mwcnt, mtcnt;

    always #5 clk = ~clk;

    wb_ext_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_cab_i(m_cab),
        .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_dat_o(m_rdat),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_cyc_o(s_cyc),
        .s_stb_o(s_stb), .s_we_o(s_we), .s_cab_o(s_cab), .s_cti_o(s_cti),
        .s_bte_o(s_bte), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .s_dat_i(s_rdat), .grant_o(grant), .timeout_cnt_o(tcnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mg = -1; mlast = N - 1; mwcnt = 0; mtcnt = 0;
    endtask

    // Compare all outputs for the current inputs, then advance the model
    // across the next rising edge.
    task automatic check_update();
        int g;
        bit act, rsp, fire;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [2:0]    e_cti;
        logic          e_we;
        logic [N-1:0]  e_gnt, e_ack, e_err, e_rty;
        #1;
        g = mg;
        act  = (g >= 0) && m_cyc[g];
        rsp  = s_ack | s_err | s_rty;
        fire = act && m_stb[g] && (mwcnt == TO) && !rsp;
        e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0; e_we = 1'b0;
        e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
        if (g >= 0) e_gnt[g] = 1'b1;
        if (act) begin
            e_adr = m_adr[g*AW +: AW];
            e_dat = m_dat[g*DW +: DW];
            e_sel = m_sel[g*SW +: SW];
            e_cti = m_cti[g*3 +: 3];
            e_we  = m_we[g];
            e_ack[g] = s_ack;
            e_err[g] = s_err | fire;
            e_rty[g] = s_rty;
        end
        chk("grant", grant, e_gnt);
        chk("s_cyc", s_cyc, act && !fire);
        chk("s_stb", s_stb, act && m_stb[g] && !fire);
        chk("s_adr", s_adr, e_adr);
        chk("s_dat", s_wdat, e_dat);
        chk("s_sel", s_sel, e_sel);
        chk("s_cti", s_cti, e_cti);
        chk("s_we", s_we, e_we);
        chk("m_ack", m_ack, e_ack);
        chk("m_err", m_err, e_err);
        chk("m_rty", m_rty, e_rty);
        chk("m_dat", m_rdat, s_rdat);
        chk("tcnt", tcnt, mtcnt);
        @(posedge clk);
        if (!act) begin
            int cand = -1;
            int lim  = (g < 0) ? N : N - 1;
            for (int k = 1; k <= lim; k++)
                if (cand < 0 && m_cyc[(mlast + k) % N]) cand = (mlast + k) % N;
            if (cand >= 0) begin mg = cand; mlast = cand; end
            else mg = -1;
            mwcnt = 0;
        end else begin
            if (fire && mtcnt < 255) mtcnt++;
            mwcnt = (rsp || !m_stb[g] || fire) ? 0 : mwcnt + 1;
        end
    endtask

    // mode 0: churning traffic, random slave replies
    // mode 1: masters hold cyc/stb, silent slave (watchdog fires)
    // mode 2: as 1, but the slave acks exactly in the would-be firing cycle
    task automatic drive(input int mode);
        int r;
        for (int i = 0; i < N; i++) begin
            if (m_cyc[i]) begin
                if (mode == 0 && $urandom_range(0, 7) == 0) begin
                    m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
                end else begin
                    m_stb[i] = (mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 1) == 1) m_adr[i*AW +: AW] = $urandom;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_adr[i*AW +: AW] = $urandom;
            end
            m_dat[i*DW +: DW] = $urandom;
            m_sel[i*SW +: SW] = SW'($urandom);
            m_cti[i*3 +: 3]   = 3'($urandom);
            m_bte[i*2 +: 2]   = 2'($urandom);
            m_we[i]  = 1'($urandom);
            m_cab[i] = 1'($urandom);
        end
        s_rdat = $urandom;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        if (mode == 0) begin
            r = $urandom_range(0, 9);
            s_ack = (r < 4); s_err = (r == 4); s_rty = (r == 5);
        end else if (mode == 2) begin
            s_ack = (mg >= 0) && m_cyc[mg] && m_stb[mg] && (mwcnt == TO);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_cyc = '0; m_stb = '0;
        m_we = '0; m_cab = '0; m_cti = '0; m_bte = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = 32'h1234_5678;
        model_reset();
        #2;
        chk("rst_grant", grant, 9'h000);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_tcnt", tcnt, 8'h00);
        chk("rst_m_dat", m_rdat, 32'h1234_5678);

        // directed single read from master 3
        @(negedge clk);
        rst_n = 1'b1;
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_adr[3*AW +: AW] = 32'h0000_1000;
        check_update();
        @(negedge clk);
        #1 chk("sr_grant", grant, 9'h008);
        chk("sr_adr", s_adr, 32'h0000_1000);
        check_update();
        @(negedge clk);
        check_update();
        @(negedge clk);
        s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        #1 chk("sr_ack", m_ack, 9'h008);
        chk("sr_rdat", m_rdat, 32'hDEAD_BEEF);
        check_update();
        @(negedge clk);
        s_ack = 1'b0; m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
        #1 chk("sr_ack_end", m_ack, 9'h000);
        check_update();

        // randomized phases, cycling through the three slave behaviours
        for (int p = 0; p < 24; p++) begin
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                drive(p % 3);
                check_update();
            end
        end

        // asynchronous reset in the middle of a transfer
        m_cyc[6] = 1'b1; m_stb[6] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1);
            check_update();
        end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk("arst_grant", grant, 9'h000);
        chk("arst_s_cyc", s_cyc, 1'b0);
        chk("arst_s_stb", s_stb, 1'b0);
        chk("arst_ack", m_ack, 9'h000);
        chk("arst_tcnt", tcnt, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_cyc = 9'h041; m_stb = 9'h041;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        check_update();
        @(negedge clk);
        #1 chk("arst_prio", grant, 9'h001);
        check_update();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
